serial_mag_comparator: RTL and testbench

//   Bit-serial magnitude comparator. Captures two WIDTH-bit operands and walks them MSB-first, one bit per clock.

---
 rtl/serial_mag_comparator.sv | 120 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_mag_comparator                                                      |
// | Bit-serial unsigned magnitude comparator, MSB-first, one bit per clock.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_g;
  logic             r_e;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;
  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_g_nxt;
  logic             w_e_nxt;
  logic             w_last_bit;

  // One step of the comparator cell on the bit currently selected by the counter.
  assign w_bit_a    = r_a[r_cnt];
  assign w_bit_b    = r_b[r_cnt];
  assign w_g_nxt    = r_g | (~w_bit_a & w_bit_b & r_e);
  assign w_e_nxt    = r_e & ~(w_bit_a ^ w_bit_b);
  assign w_last_bit = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last_bit) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flags are loaded on the edge that evaluates bit 0 so they are valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= C_CNT_MAX;
      r_a   <= '0;
      r_b   <= '0;
      r_g   <= 1'b0;
      r_e   <= 1'b1;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_g   <= 1'b0;
            r_e   <= 1'b1;
            r_cnt <= C_CNT_MAX;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
          end
        end
        RUN: begin
          r_g <= w_g_nxt;
          r_e <= w_e_nxt;
          if (w_last_bit) begin
            r_lt <= w_g_nxt;
            r_eq <= w_e_nxt;
            r_gt <= ~w_g_nxt & ~w_e_nxt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign a_lt_b = r_lt;
  assign a_eq_b = r_eq;
  assign a_gt_b = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// Scoreboard bench for serial_mag_comparator: driver pushes hand-computed
// results, a negedge monitor pops and compares whenever done is seen.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             busy;
  logic             done;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_gt_b;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b),
    .a_gt_b (a_gt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  lt;
    logic  eq;
    logic  gt;
    int    dcyc;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_lt"}, 32'(a_lt_b), 32'(e.lt));
        chk({e.name, "_eq"}, 32'(a_eq_b), 32'(e.eq));
        chk({e.name, "_gt"}, 32'(a_gt_b), 32'(e.gt));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.dcyc));
      end
    end
  end

  task automatic push(input string nm, input logic lt, input logic eq, input logic gt);
    exp_t e;
    e.lt = lt; e.eq = eq; e.gt = gt; e.dcyc = cyc + WIDTH; e.name = nm;
    sb.push_back(e);
  endtask

  // Drives one start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic lt, input logic eq, input logic gt, input bit expect_done);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    if (expect_done) push(nm, lt, eq, gt);
    chk({nm, "_flags_cleared"}, {29'd0, a_lt_b, a_eq_b, a_gt_b}, 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int k;

    // Reset with start held high: nothing moves.
    start = 1'b1; a_in = 8'h12; b_in = 8'h34;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {27'd0, busy, done, a_lt_b, a_eq_b, a_gt_b}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push("post_reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done("post_reset");

    issue("eq_5a", 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done("eq_5a");
    repeat (2) @(negedge clk);
    chk("eq_5a_hold", {29'd0, a_lt_b, a_eq_b, a_gt_b}, 32'b010);
    chk("idle_not_busy", 32'(busy), 32'd0);

    issue("lt_lsb", 8'h3C, 8'h3D, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done("lt_lsb");

    // MSB decides; g and e must stay 0 for every later bit.
    issue("gt_msb", 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk("gt_msb_g_frozen", 32'(dut.r_g), 32'd0);
      chk("gt_msb_e_frozen", 32'(dut.r_e), 32'd0);
    end
    wait_done("gt_msb");

    // Start mid-run with different operands must be ignored.
    issue("ignore_mid", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_mid_busy", 32'(busy), 32'd1);
    wait_done("ignore_mid");

    // Start held high: second capture on the first edge back in IDLE (k+WIDTH+2).
    @(negedge clk);
    start = 1'b1; a_in = 8'h01; b_in = 8'h02;
    @(posedge clk);
    #1;
    k = cyc;
    push("b2b_first", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    a_in = 8'h09; b_in = 8'h03;
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    chk("b2b_second_cycle", 32'(cyc), 32'(k + WIDTH + 2));
    push("b2b_second", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b");

    // Reset while bit 4 is the next bit to evaluate: no done pulse.
    issue("abort", 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_cnt_before", 32'(dut.r_cnt), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, busy, done, a_lt_b, a_eq_b, a_gt_b}, 32'd0);
    chk("abort_cnt", 32'(dut.r_cnt), 32'd7);
    chk("abort_e", 32'(dut.r_e), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);

    issue("gt_after_abort", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("gt_after_abort");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
